// File: rtl/key_dispatcher_if.sv
// Handshake bundle between the key dispatcher, the top-level control FSM and the decrypt cores.
// With KEY_DISPATCH_STATS_EN defined the bundle also carries keys_tried and cycles.
interface key_dispatcher_if #(
  parameter int N_CORES = 4
);
  logic               start;
  logic [N_CORES-1:0] req;
  logic [N_CORES-1:0] miss;
  logic [N_CORES-1:0] hit;
  logic [N_CORES-1:0] grant;
  logic [21:0]        key_out;
  logic               busy;
  logic               done;
  logic               success;
  logic [21:0]        result_key;
`ifdef KEY_DISPATCH_STATS_EN
  logic [21:0]        keys_tried;
  logic [31:0]        cycles;

  modport master (
    output start, req, miss, hit,
    input  grant, key_out, busy, done, success, result_key, keys_tried, cycles
  );

  modport slave (
    input  start, req, miss, hit,
    output grant, key_out, busy, done, success, result_key, keys_tried, cycles
  );
`else
  modport master (
    output start, req, miss, hit,
    input  grant, key_out, busy, done, success, result_key
  );

  modport slave (
    input  start, req, miss, hit,
    output grant, key_out, busy, done, success, result_key
  );
`endif
endinterface

// File: rtl/key_dispatcher.sv
// Round-robin RC4 key scheduler: hands successive 22-bit LFSR keys to N decrypt cores until a hit or exhaustion.
// Optional KEY_DISPATCH_STATS_EN adds keys_tried / cycles counters on the interface.
//
// state   | meaning
// S_IDLE  | waiting for start, outputs quiet
// S_RUN   | issuing keys to requesting cores
// S_DRAIN | key space issued, waiting for outstanding cores to report
// S_DONE  | search finished, success/result_key held
module key_dispatcher #(
  parameter int          N_CORES  = 4,
  parameter int unsigned MAX_KEYS = 4194303
) (
  input  logic          clk,
  input  logic          reset,
  key_dispatcher_if.slave kd
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam int          PW    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [21:0] SEED  = 22'h3FFFFF;
  localparam logic [21:0] MAX_L = MAX_KEYS[21:0];
  localparam logic [PW-1:0] LAST = PW'(N_CORES - 1);

  state_e             state_q, state_d;
  logic [21:0]        lfsr_q, lfsr_d;
  logic [21:0]        issued_q, issued_d;
  logic [21:0]        key_out_q, key_out_d;
  logic [21:0]        result_q, result_d;
  logic [N_CORES-1:0] out_q, out_d;
  logic [N_CORES-1:0] grant_q, grant_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic               success_q, success_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [21:0]        core_key_q [N_CORES];

  logic [N_CORES-1:0] hit_v, ack_v, elig;
  logic [21:0]        hit_key;
  logic [PW-1:0]      pick;
  logic               pick_ok;
  logic               start_ok;

  // Acknowledgements only count for cores that actually hold a key.
  always_comb begin
    hit_v    = kd.hit & out_q;
    ack_v    = (kd.hit | kd.miss) & out_q;
    elig     = kd.req & ~out_q;
    start_ok = kd.start && (state_q == S_IDLE || state_q == S_DONE);
    hit_key  = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (hit_v[i]) hit_key = core_key_q[i];
    end
    // Round robin: first eligible above rr_q, then wrap to the low indices.
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (!pick_ok && elig[i] && (PW'(i) > rr_q)) begin
        pick    = PW'(i);
        pick_ok = 1'b1;
      end
    end
    for (int i = 0; i < N_CORES; i++) begin
      if (!pick_ok && elig[i] && (PW'(i) <= rr_q)) begin
        pick    = PW'(i);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    issued_d  = issued_q;
    out_d     = out_q;
    grant_d   = '0;
    key_out_d = key_out_q;
    rr_d      = rr_q;
    success_d = success_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d   = S_RUN;
          lfsr_d    = SEED;
          issued_d  = '0;
          out_d     = '0;
          rr_d      = LAST;
          success_d = 1'b0;
          result_d  = '0;
        end
      end
      S_RUN: begin
        out_d = out_q & ~ack_v;
        if (|hit_v) begin
          state_d   = S_DONE;
          success_d = 1'b1;
          result_d  = hit_key;
        end else if (issued_q == MAX_L) begin
          state_d = S_DRAIN;
        end else if (pick_ok) begin
          grant_d   = N_CORES'(1) << pick;
          out_d     = out_d | grant_d;
          key_out_d = lfsr_q;
          lfsr_d    = {lfsr_q[20:0], lfsr_q[21] ^ lfsr_q[0]};
          issued_d  = issued_q + 22'd1;
          rr_d      = pick;
        end
      end
      S_DRAIN: begin
        out_d = out_q & ~ack_v;
        if (|hit_v) begin
          state_d   = S_DONE;
          success_d = 1'b1;
          result_d  = hit_key;
        end else if (out_q == '0) begin
          state_d   = S_DONE;
          success_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q    <= SEED;
      issued_q  <= '0;
      out_q     <= '0;
      grant_q   <= '0;
      key_out_q <= '0;
      rr_q      <= LAST;
      success_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      issued_q  <= issued_d;
      out_q     <= out_d;
      grant_q   <= grant_d;
      key_out_q <= key_out_d;
      rr_q      <= rr_d;
      success_q <= success_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (reset)           core_key_q[i] <= '0;
      else if (grant_d[i]) core_key_q[i] <= key_out_d;
    end
  end

  assign kd.grant      = grant_q;
  assign kd.key_out    = key_out_q;
  assign kd.busy       = busy_q;
  assign kd.done       = done_q;
  assign kd.success    = success_q;
  assign kd.result_key = result_q;

`ifdef KEY_DISPATCH_STATS_EN
  logic [21:0] tried_q;
  logic [31:0] cyc_q;
  logic        active;

  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      tried_q <= '0;
      cyc_q   <= '0;
    end else if (active) begin
      tried_q <= tried_q + 22'($countones(ack_v));
      if (cyc_q != '1) cyc_q <= cyc_q + 32'd1;
    end
  end

  assign kd.keys_tried = tried_q;
  assign kd.cycles     = cyc_q;
`endif

endmodule
